// File: rtl/axi4_lite_protocol_checker.sv
// Passive AXI4-Lite link monitor: flags stability, response-encoding, ordering
// and stall-timeout violations as registered pulses, sticky flags and counters.
module axi4_lite_protocol_checker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int COUNTER_WIDTH   = 16,
    parameter int MAX_OUTSTANDING = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     awvalid_i,
    input  logic                     awready_i,
    input  logic [ADDR_WIDTH-1:0]    awaddr_i,
    input  logic                     wvalid_i,
    input  logic                     wready_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [DATA_WIDTH/8-1:0]  wstrb_i,
    input  logic                     bvalid_i,
    input  logic                     bready_i,
    input  logic [1:0]               bresp_i,
    input  logic                     arvalid_i,
    input  logic                     arready_i,
    input  logic [ADDR_WIDTH-1:0]    araddr_i,
    input  logic                     rvalid_i,
    input  logic                     rready_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     clear_errors_i,
    output logic [11:0]              error_pulse_o,
    output logic [11:0]              error_sticky_o,
    output logic                     first_error_valid_o,
    output logic [3:0]               first_error_id_o,
    output logic [COUNTER_WIDTH-1:0] error_count_o,
    output logic [COUNTER_WIDTH-1:0] write_txn_count_o,
    output logic [COUNTER_WIDTH-1:0] read_txn_count_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int TO_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]          PEND_MAX = 4'(MAX_OUTSTANDING);
    localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] TO_FULL  = TO_WIDTH'(TIMEOUT_CYCLES);

    logic aw_stall, w_stall, ar_stall, r_stall, b_stall;
    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;

    logic                     aw_stall_q, w_stall_q, ar_stall_q, r_stall_q, b_stall_q;
    logic [ADDR_WIDTH-1:0]    awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0]    wstrb_q;
    logic [1:0]               bresp_q, rresp_q;
    logic [3:0]               aw_pend_q, w_pend_q, ar_pend_q;
    logic [TO_WIDTH-1:0]      aw_to_q, aw_to_d, ar_to_q, ar_to_d;
    logic [11:0]              viol;
    logic [11:0]              pulse_q, sticky_q, sticky_d;
    logic                     first_valid_q, first_valid_d;
    logic [3:0]               first_id_q, first_id_d, lowest_idx;
    logic [COUNTER_WIDTH-1:0] err_cnt_q, err_cnt_d, wtxn_q, rtxn_q;

    assign aw_stall = awvalid_i & ~awready_i;
    assign w_stall  = wvalid_i  & ~wready_i;
    assign ar_stall = arvalid_i & ~arready_i;
    assign r_stall  = rvalid_i  & ~rready_i;
    assign b_stall  = bvalid_i  & ~bready_i;
    assign aw_hs    = awvalid_i & awready_i;
    assign w_hs     = wvalid_i  & wready_i;
    assign ar_hs    = arvalid_i & arready_i;
    assign r_hs     = rvalid_i  & rready_i;
    assign b_hs     = bvalid_i  & bready_i;

    function automatic logic [3:0] pend_next(input logic [3:0] cur, input logic inc,
                                             input logic dec);
        if (inc && !dec && cur < PEND_MAX) return cur + 4'd1;
        if (dec && !inc && cur != 4'd0) return cur - 4'd1;
        return cur;
    endfunction

    // Stall counters saturate at TIMEOUT_CYCLES so the timeout fires only once per stall.
    assign aw_to_d = !aw_stall ? '0 : (aw_to_q == TO_FULL) ? aw_to_q : aw_to_q + TO_WIDTH'(1);
    assign ar_to_d = !ar_stall ? '0 : (ar_to_q == TO_FULL) ? ar_to_q : ar_to_q + TO_WIDTH'(1);

    always_comb begin
        viol     = '0;
        viol[0]  = aw_stall_q && (!awvalid_i || awaddr_i != awaddr_q);
        viol[1]  = w_stall_q  && (!wvalid_i || wdata_i != wdata_q || wstrb_i != wstrb_q);
        viol[2]  = ar_stall_q && (!arvalid_i || araddr_i != araddr_q);
        viol[3]  = r_stall_q  && (!rvalid_i || rdata_i != rdata_q || rresp_i != rresp_q);
        viol[4]  = b_stall_q  && (!bvalid_i || bresp_i != bresp_q);
        viol[5]  = bvalid_i && bresp_i == 2'b01;
        viol[6]  = rvalid_i && rresp_i == 2'b01;
        viol[7]  = wvalid_i && wstrb_i == '0;
        viol[8]  = bvalid_i && (aw_pend_q == 4'd0 || w_pend_q == 4'd0);
        viol[9]  = rvalid_i && ar_pend_q == 4'd0;
        viol[10] = aw_stall && aw_to_q == TO_LAST;
        viol[11] = ar_stall && ar_to_q == TO_LAST;
    end

    always_comb begin
        lowest_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (viol[i]) lowest_idx = 4'(i);
        end
    end

    // A clear in the same cycle as a new violation still records that violation.
    always_comb begin
        sticky_d      = (clear_errors_i ? 12'd0 : sticky_q) | viol;
        first_valid_d = clear_errors_i ? 1'b0 : first_valid_q;
        first_id_d    = clear_errors_i ? 4'd0 : first_id_q;
        err_cnt_d     = clear_errors_i ? '0 : err_cnt_q;
        if (viol != '0) begin
            if (err_cnt_d != '1) err_cnt_d = err_cnt_d + COUNTER_WIDTH'(1);
            if (!first_valid_d) begin
                first_valid_d = 1'b1;
                first_id_d    = lowest_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_stall_q <= 1'b0;  w_stall_q <= 1'b0;  ar_stall_q <= 1'b0;
            r_stall_q  <= 1'b0;  b_stall_q <= 1'b0;
            awaddr_q   <= '0;    araddr_q  <= '0;
            wdata_q    <= '0;    rdata_q   <= '0;    wstrb_q <= '0;
            bresp_q    <= '0;    rresp_q   <= '0;
            aw_pend_q  <= '0;    w_pend_q  <= '0;    ar_pend_q <= '0;
            aw_to_q    <= '0;    ar_to_q   <= '0;
            pulse_q    <= '0;    sticky_q  <= '0;
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
            err_cnt_q  <= '0;    wtxn_q    <= '0;    rtxn_q <= '0;
        end else begin
            aw_stall_q <= aw_stall;  w_stall_q <= w_stall;  ar_stall_q <= ar_stall;
            r_stall_q  <= r_stall;   b_stall_q <= b_stall;
            awaddr_q   <= awaddr_i;  araddr_q  <= araddr_i;
            wdata_q    <= wdata_i;   rdata_q   <= rdata_i;  wstrb_q <= wstrb_i;
            bresp_q    <= bresp_i;   rresp_q   <= rresp_i;
            aw_pend_q  <= pend_next(aw_pend_q, aw_hs, b_hs);
            w_pend_q   <= pend_next(w_pend_q, w_hs, b_hs);
            ar_pend_q  <= pend_next(ar_pend_q, ar_hs, r_hs);
            aw_to_q    <= aw_to_d;
            ar_to_q    <= ar_to_d;
            pulse_q    <= viol;
            sticky_q   <= sticky_d;
            first_valid_q <= first_valid_d;
            first_id_q    <= first_id_d;
            err_cnt_q  <= err_cnt_d;
            if (b_hs) wtxn_q <= wtxn_q + COUNTER_WIDTH'(1);
            if (r_hs) rtxn_q <= rtxn_q + COUNTER_WIDTH'(1);
        end
    end

    assign error_pulse_o       = pulse_q;
    assign error_sticky_o      = sticky_q;
    assign first_error_valid_o = first_valid_q;
    assign first_error_id_o    = first_id_q;
    assign error_count_o       = err_cnt_q;
    assign write_txn_count_o   = wtxn_q;
    assign read_txn_count_o    = rtxn_q;
endmodule

// File: tb/tb_axi4_lite_protocol_checker.sv
// Bench for axi4_lite_protocol_checker: directed scenarios plus random traffic,
// every cycle compared against a sample-history reference model.
module tb_axi4_lite_protocol_checker;
    localparam int T       = 16;
    localparam int MAX_OUT = 15;
    localparam int CW      = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready, clr;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [11:0] error_pulse, error_sticky;
    logic        first_error_valid;
    logic [3:0]  first_error_id;
    logic [CW-1:0] error_count, write_txn_count, read_txn_count;

    axi4_lite_protocol_checker dut (
        .clk_i(clk), .rst_i(rst),
        .awvalid_i(awvalid), .awready_i(awready), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_i(wready), .wdata_i(wdata), .wstrb_i(wstrb),
        .bvalid_i(bvalid), .bready_i(bready), .bresp_i(bresp),
        .arvalid_i(arvalid), .arready_i(arready), .araddr_i(araddr),
        .rvalid_i(rvalid), .rready_i(rready), .rdata_i(rdata), .rresp_i(rresp),
        .clear_errors_i(clr),
        .error_pulse_o(error_pulse), .error_sticky_o(error_sticky),
        .first_error_valid_o(first_error_valid), .first_error_id_o(first_error_id),
        .error_count_o(error_count), .write_txn_count_o(write_txn_count),
        .read_txn_count_o(read_txn_count)
    );

    // clock / reset
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic awv, awr, wv, wr, bv, br, arv, arr, rv, rr;
        logic [31:0] awaddr, araddr, wdata, rdata;
        logic [3:0] wstrb;
        logic [1:0] bresp, rresp;
    } sample_t;

    sample_t prev;
    bit      have_prev;
    int m_aw, m_w, m_ar, aw_run, ar_run;
    int m_wtx, m_rtx, m_cnt, m_id;
    bit m_fv;
    logic [11:0] m_sticky;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > MAX_OUT) ? MAX_OUT : v;
    endfunction

    // Reference model: judges each sampled cycle against the previous sample and
    // transaction tallies kept as plain integers.
    task automatic model_step(input sample_t s, input bit r, input bit c);
        logic [11:0] v;
        v = '0;
        if (r) begin
            have_prev = 0; m_aw = 0; m_w = 0; m_ar = 0; aw_run = 0; ar_run = 0;
            m_wtx = 0; m_rtx = 0; m_cnt = 0; m_id = 0; m_fv = 0; m_sticky = '0;
        end else begin
            if (have_prev) begin
                v[0] = prev.awv && !prev.awr && (!s.awv || s.awaddr != prev.awaddr);
                v[1] = prev.wv && !prev.wr && (!s.wv || s.wdata != prev.wdata || s.wstrb != prev.wstrb);
                v[2] = prev.arv && !prev.arr && (!s.arv || s.araddr != prev.araddr);
                v[3] = prev.rv && !prev.rr && (!s.rv || s.rdata != prev.rdata || s.rresp != prev.rresp);
                v[4] = prev.bv && !prev.br && (!s.bv || s.bresp != prev.bresp);
            end
            v[5] = s.bv && s.bresp == 2'b01;
            v[6] = s.rv && s.rresp == 2'b01;
            v[7] = s.wv && s.wstrb == 4'b0000;
            v[8] = s.bv && (m_aw == 0 || m_w == 0);
            v[9] = s.rv && m_ar == 0;
            aw_run = (s.awv && !s.awr) ? aw_run + 1 : 0;
            ar_run = (s.arv && !s.arr) ? ar_run + 1 : 0;
            v[10] = aw_run == T;
            v[11] = ar_run == T;
            m_aw = clamp(m_aw + int'(s.awv && s.awr) - int'(s.bv && s.br));
            m_w  = clamp(m_w  + int'(s.wv && s.wr)   - int'(s.bv && s.br));
            m_ar = clamp(m_ar + int'(s.arv && s.arr) - int'(s.rv && s.rr));
            if (s.bv && s.br) m_wtx = (m_wtx + 1) % (1 << CW);
            if (s.rv && s.rr) m_rtx = (m_rtx + 1) % (1 << CW);
            if (c) begin
                m_sticky = '0; m_cnt = 0; m_fv = 0; m_id = 0;
            end
            m_sticky |= v;
            if (v != 0) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (!m_fv) begin
                    m_fv = 1;
                    for (int i = 11; i >= 0; i--) if (v[i]) m_id = i;
                end
            end
            prev = s;
            have_prev = 1;
        end
        exp_q.push_back(v);
    endtask

    task automatic compare_all();
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'(1), 64'(0));
            return;
        end
        e = exp_q.pop_front();
        check("pulse", 64'(error_pulse), 64'(e));
        check("sticky", 64'(error_sticky), 64'(m_sticky));
        check("first_valid", 64'(first_error_valid), 64'(m_fv));
        check("first_id", 64'(first_error_id), 64'(m_id));
        check("err_count", 64'(error_count), 64'(m_cnt));
        check("wtxn", 64'(write_txn_count), 64'(m_wtx));
        check("rtxn", 64'(read_txn_count), 64'(m_rtx));
    endtask

    // driver tasks
    task automatic idle();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; rvalid = 0; rready = 0; clr = 0;
        awaddr = 0; araddr = 0; wdata = 0; rdata = 0; wstrb = 4'hF; bresp = 0; rresp = 0;
    endtask

    task automatic step();
        sample_t s;
        bit r, c;
        s.awv = awvalid; s.awr = awready; s.wv = wvalid; s.wr = wready;
        s.bv = bvalid; s.br = bready; s.arv = arvalid; s.arr = arready;
        s.rv = rvalid; s.rr = rready; s.awaddr = awaddr; s.araddr = araddr;
        s.wdata = wdata; s.rdata = rdata; s.wstrb = wstrb; s.bresp = bresp; s.rresp = rresp;
        r = rst; c = clr;
        @(posedge clk);
        #1;
        cyc++;
        model_step(s, r, c);
        compare_all();
    endtask

    task automatic do_reset();
        idle();
        rst = 1; step(); step();
        rst = 0;
    endtask

    int to_pulses, to_when, keep_pct, rdy_pct;

    initial begin
        idle();
        do_reset();
        check("rst_pulse", 64'(error_pulse), 64'(0));
        check("rst_count", 64'(error_count), 64'(0));

        // legal write, then a B with nothing outstanding
        awvalid = 1; awready = 1; wvalid = 1; wready = 1; awaddr = 32'h40; wdata = 32'hCAFE;
        step();
        idle(); step();
        bvalid = 1; bready = 1; step();
        check("legal_wtxn", 64'(write_txn_count), 64'(1));
        check("legal_sticky", 64'(error_sticky), 64'(0));
        step();
        check("extra_b_pulse", 64'(error_pulse), 64'(12'h100));

        // AWADDR changes while stalled
        do_reset();
        awvalid = 1; awaddr = 32'h10; step();
        awaddr = 32'h14; step();
        check("stab_pulse", 64'(error_pulse), 64'(12'h001));
        check("stab_first", 64'(first_error_id), 64'(0));
        check("stab_count", 64'(error_count), 64'(1));
        awready = 1; step();
        check("stab_one_cycle", 64'(error_pulse), 64'(0));

        // orphan R with EXOKAY
        do_reset();
        rvalid = 1; rready = 1; rresp = 2'b01; step();
        check("orphan_pulse", 64'(error_pulse), 64'(12'h240));
        check("orphan_first", 64'(first_error_id), 64'(6));
        check("orphan_count", 64'(error_count), 64'(1));

        // AR stall timeout
        do_reset();
        arvalid = 1; araddr = 32'h20;
        to_pulses = 0; to_when = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (error_pulse[11]) begin
                to_pulses++;
                to_when = i;
            end
        end
        check("to_pulses", 64'(to_pulses), 64'(1));
        check("to_when", 64'(to_when), 64'(T));
        arready = 1; step();
        check("to_after_hs", 64'(error_pulse), 64'(0));
        idle(); rvalid = 1; rready = 1; step();
        check("to_r_ok", 64'(error_pulse), 64'(0));

        // clear colliding with a new WSTRB violation
        do_reset();
        awvalid = 1; awaddr = 32'h10; step();
        awaddr = 32'h14; step();
        awready = 1; wvalid = 1; wready = 1; wstrb = 4'h0; step();
        check("clr_pre_sticky", 64'(error_sticky), 64'(12'h081));
        awvalid = 0; awready = 0; clr = 1; step();
        check("clr_sticky", 64'(error_sticky), 64'(12'h080));
        check("clr_count", 64'(error_count), 64'(1));
        check("clr_first", 64'(first_error_id), 64'(7));

        // reset mid-transaction discards pending state
        do_reset();
        awvalid = 1; awready = 1; wvalid = 1; wready = 1; wstrb = 4'h0; step();
        idle(); rst = 1; step();
        check("midrst_sticky", 64'(error_sticky), 64'(0));
        check("midrst_count", 64'(error_count), 64'(0));
        rst = 0; bvalid = 1; bready = 1; step();
        check("midrst_b_pulse", 64'(error_pulse), 64'(12'h100));

        // random traffic in segments of differing backpressure
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            rdy_pct  = (seg % 2 == 0) ? 60 : 3;
            keep_pct = (seg % 2 == 0) ? 90 : 98;
            for (int c = 0; c < 500; c++) begin
                if (!(awvalid && !awready && $urandom_range(0, 99) < keep_pct)) begin
                    awvalid = 1'($urandom_range(0, 1));
                    awaddr  = 32'h10 + 32'($urandom_range(0, 2)) * 4;
                end
                if (!(wvalid && !wready && $urandom_range(0, 99) < keep_pct)) begin
                    wvalid = 1'($urandom_range(0, 1));
                    wdata  = $urandom;
                    wstrb  = 4'($urandom_range(0, 15));
                end
                if (!(arvalid && !arready && $urandom_range(0, 99) < keep_pct)) begin
                    arvalid = 1'($urandom_range(0, 1));
                    araddr  = 32'h20 + 32'($urandom_range(0, 2)) * 4;
                end
                if (!(bvalid && !bready && $urandom_range(0, 99) < keep_pct)) begin
                    bvalid = ($urandom_range(0, 99) < 30);
                    bresp  = 2'($urandom_range(0, 3));
                end
                if (!(rvalid && !rready && $urandom_range(0, 99) < keep_pct)) begin
                    rvalid = ($urandom_range(0, 99) < 30);
                    rresp  = 2'($urandom_range(0, 3));
                    rdata  = $urandom;
                end
                awready = ($urandom_range(0, 99) < rdy_pct);
                wready  = ($urandom_range(0, 99) < rdy_pct);
                arready = ($urandom_range(0, 99) < rdy_pct);
                bready  = ($urandom_range(0, 99) < 70);
                rready  = ($urandom_range(0, 99) < 70);
                clr     = ($urandom_range(0, 99) < 3);
                rst     = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        rst = 0;
        idle(); step();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_lite_protocol_checker.md
# axi4_lite_protocol_checker

Synthesizable, parametrised AXI4-Lite protocol checker. It passively monitors all five channels of one AXI4-Lite link between master and slave and flags handshake, stability, response-encoding, ordering and timeout violations. Errors are reported as registered one-cycle pulses, sticky flags, a first-error capture and counters. It sits beside the AXI4-Lite master/slave pair in both simulation and silicon and drives no bus signals.

## Interface
- ADDR_WIDTH, 32, address width of AWADDR/ARADDR
- DATA_WIDTH, 32, width of WDATA/RDATA; must be 32 or 64; WSTRB width = DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, consecutive VALID-without-READY cycles that count as a stall error; must be ≥2
- COUNTER_WIDTH, 16, width of error and transaction counters
- MAX_OUTSTANDING, 15, saturation limit of the per-channel pending counters (4-bit)
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY  in  1 each  channel handshakes
- AWADDR, ARADDR  in  ADDR_WIDTH  addresses
- WDATA, RDATA  in  DATA_WIDTH  data
- WSTRB  in  DATA_WIDTH/8  write strobes
- BRESP, RRESP  in  2  responses
- clear_errors  in  1  clears the sticky flags, first-error capture and error_count
- error_pulse  out  12  per-check violation, high for one cycle
- error_sticky  out  12  per-check flag, held until clear_errors or reset
- first_error_valid  out  1  first_error_id holds a captured value
- first_error_id  out  4  index of the lowest-numbered check that fired in the first violating cycle
- error_count  out  COUNTER_WIDTH  number of cycles with ≥1 violation; saturates at all-ones
- write_txn_count, read_txn_count  out  COUNTER_WIDTH  completed B / R handshakes; wrap modulo 2^COUNTER_WIDTH

## Operation
- Check indices:
  - 0: AWVALID dropped or AWADDR changed while stalled.
  - 1: WVALID dropped or WDATA/WSTRB changed while stalled.
  - 2: ARVALID dropped or ARADDR changed while stalled.
  - 3: RVALID dropped or RDATA/RRESP changed while stalled.
  - 4: BVALID dropped or BRESP changed while stalled.
  - 5: BVALID with BRESP=2'b01 (EXOKAY is illegal on AXI4-Lite).
  - 6: RVALID with RRESP=2'b01.
  - 7: WVALID with WSTRB all-zero.
  - 8: BVALID while aw_pending=0 or w_pending=0.
  - 9: RVALID while ar_pending=0.
  - 10: AW stall timeout.
  - 11: AR stall timeout.
- "Stalled" means VALID=1 and READY=0 on the previous rising edge. In that case, on the current edge, VALID must still be 1 and the payload must equal the registered copy.
- Pending counters (4-bit, saturating at MAX_OUTSTANDING, never below 0):
  - aw_pending: +1 on AW handshake, −1 on B handshake.
  - w_pending: +1 on W handshake, −1 on B handshake.
  - ar_pending: +1 on AR handshake, −1 on R handshake.
  - Increment and decrement in the same cycle leave the counter unchanged.
- Checks 8 and 9 use the counter values registered before the current edge. A B or R response in the same cycle as its enabling address/data handshake is therefore an error.
- Timeouts: a per-channel stall counter increments while VALID=1 and READY=0, and resets to 0 otherwise. When it reaches TIMEOUT_CYCLES it fires once, then holds without further pulses until the stall ends.
- Stall history valid bits are cleared by reset, so there are no stability checks on the first edge after reset release.
- clear_errors and a new violation in the same cycle: the new violation sets its sticky bit, error_count becomes 1, and first_error_id captures the new index.

## Timing
- Reset values: all outputs, pending counters, stall counters and history registers are 0.
- Violation latency: a violation sampled on edge N appears on error_pulse and error_sticky after edge N (one-cycle registered latency).
- error_count and first_error_* update on the same edge as error_pulse.
- first_error_* is captured only while first_error_valid=0.
- Transaction counters update the edge after their handshake.
- Timeout: a stall starting on edge S produces error_pulse[10/11] after edge S+TIMEOUT_CYCLES−1.
- Reset mid-transaction: all state is discarded. Any B/R arriving after reset release is flagged by check 8/9.
- The checker has no combinational path from inputs to outputs.

## Test plan
- Legal write: AW and W handshake together, B with BRESP=00 two cycles later → all error outputs stay 0; write_txn_count=1; aw_pending and w_pending return to 0.
- Stability violation: AWVALID=1, AWREADY=0, then AWADDR changes 0x10→0x14 on the next edge → error_pulse[0] high for exactly one cycle; error_sticky[0]=1; first_error_id=0; error_count=1.
- Orphan response and EXOKAY: RVALID=1 with RRESP=01 and no AR issued → error_pulse[6] and error_pulse[9] in the same cycle; first_error_id=6; error_count=1.
- Timeout: with TIMEOUT_CYCLES=16, ARVALID held high and ARREADY low for 40 cycles → exactly one pulse on bit 11, 16 cycles after stall start. ARREADY then asserts → no further pulse; ar_pending=1.
- Clear and collision: sticky bits 0 and 7 set; clear_errors asserted on the same cycle as a WSTRB=0000 violation → error_sticky=bit 7 only; error_count=1; first_error_id=7.
- Reset mid-burst: reset is pulsed while aw_pending=1, then BVALID is driven → all outputs return to 0 during reset; error_pulse[8] fires after the B.
